// File: rtl/aes_pkg.sv
// Shared AES definitions: sizes, round-constant seed, word type and GF(2^8) helpers.
package aes_pkg;

    localparam int          AES_NR    = 10;
    localparam int          AES_KEY_W = 128;
    localparam logic [7:0]  RCON_INIT = 8'h01;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        KEYED = 2'd1,
        FINAL = 2'd2
    } ks_state_e;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
    endfunction

    function automatic word_t rot_word(input word_t w);
        return {w[23:0], w[31:24]};
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// AES forward S-box, combinational: multiplicative inverse in GF(2^8) followed by the affine map.
module aes_sbox
    import aes_pkg::*;
(
    input  logic [7:0] byte_i,
    output logic [7:0] byte_o
);

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = '0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    logic [7:0] x2, x3, x12, x15, x240, x252, inv;

    // Inverse as b^254 via an addition chain; 0 maps to 0 naturally.
    always_comb begin
        x2   = gf_mul(byte_i, byte_i);
        x3   = gf_mul(x2, byte_i);
        x12  = gf_mul(gf_mul(x3, x3), gf_mul(x3, x3));
        x15  = gf_mul(x12, x3);
        x240 = gf_mul(x15, x15);
        x240 = gf_mul(x240, x240);
        x240 = gf_mul(x240, x240);
        x240 = gf_mul(x240, x240);
        x252 = gf_mul(x240, x12);
        inv  = gf_mul(x252, x2);
    end

    assign byte_o = inv
                  ^ {inv[6:0], inv[7]}
                  ^ {inv[5:0], inv[7:6]}
                  ^ {inv[4:0], inv[7:5]}
                  ^ {inv[3:0], inv[7:4]}
                  ^ 8'h63;

endmodule

// File: rtl/aes_round_key_gen.sv
// On-the-fly AES-128 key schedule, one expansion step per advance.
// Optional KS_REWIND_EN adds a master-key register so rewind can restart at round 0.
//
// state | meaning
// IDLE  | no key loaded, round_ks invalid
// KEYED | valid key for round_idx < NR
// FINAL | valid key for round_idx == NR, advance ignored
module aes_round_key_gen
    import aes_pkg::*;
#(
    parameter int KEY_W   = AES_KEY_W,
    parameter int NR      = AES_NR,
    parameter int ROUND_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic [KEY_W-1:0]   key,
    input  logic               advance,
    input  logic               rewind,
    output logic [KEY_W-1:0]   round_ks,
    output logic [ROUND_W-1:0] round_idx,
    output logic               ks_valid,
    output logic               ks_last
);

    ks_state_e          state_q, state_d;
    logic [KEY_W-1:0]   round_ks_q, round_ks_d;
    logic [ROUND_W-1:0] round_idx_q, round_idx_d;
    logic [7:0]         rcon_q, rcon_d;
    logic               ks_valid_q, ks_valid_d;
    logic               ks_last_q, ks_last_d;

    word_t w0, w1, w2, w3, rot_w, sub_w, n0, n1, n2, n3;

    assign w0    = round_ks_q[127:96];
    assign w1    = round_ks_q[95:64];
    assign w2    = round_ks_q[63:32];
    assign w3    = round_ks_q[31:0];
    assign rot_w = rot_word(w3);

    for (genvar i = 0; i < 4; i++) begin : g_subword
        aes_sbox u_sbox (
            .byte_i (rot_w[8*i +: 8]),
            .byte_o (sub_w[8*i +: 8])
        );
    end

    assign n0 = w0 ^ sub_w ^ {rcon_q, 24'h0};
    assign n1 = w1 ^ n0;
    assign n2 = w2 ^ n1;
    assign n3 = w3 ^ n2;

`ifdef KS_REWIND_EN
    logic [KEY_W-1:0] master_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)      master_q <= '0;
        else if (load) master_q <= key;
    end
`else
    logic unused_rewind;
    assign unused_rewind = rewind;
`endif

    always_comb begin
        state_d     = state_q;
        round_ks_d  = round_ks_q;
        round_idx_d = round_idx_q;
        rcon_d      = rcon_q;
        if (load) begin
            state_d     = KEYED;
            round_ks_d  = key;
            round_idx_d = '0;
            rcon_d      = RCON_INIT;
        end
`ifdef KS_REWIND_EN
        else if (rewind && state_q != IDLE) begin
            state_d     = KEYED;
            round_ks_d  = master_q;
            round_idx_d = '0;
            rcon_d      = RCON_INIT;
        end
`endif
        else if (advance && state_q == KEYED && round_idx_q < ROUND_W'(NR)) begin
            round_ks_d  = {n0, n1, n2, n3};
            round_idx_d = round_idx_q + ROUND_W'(1);
            rcon_d      = xtime(rcon_q);
            state_d     = (round_idx_q == ROUND_W'(NR - 1)) ? FINAL : KEYED;
        end
        ks_valid_d = (state_d != IDLE);
        ks_last_d  = (state_d == FINAL);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            round_ks_q  <= '0;
            round_idx_q <= '0;
            rcon_q      <= RCON_INIT;
            ks_valid_q  <= 1'b0;
            ks_last_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            round_ks_q  <= round_ks_d;
            round_idx_q <= round_idx_d;
            rcon_q      <= rcon_d;
            ks_valid_q  <= ks_valid_d;
            ks_last_q   <= ks_last_d;
        end
    end

    assign round_ks  = round_ks_q;
    assign round_idx = round_idx_q;
    assign ks_valid  = ks_valid_q;
    assign ks_last   = ks_last_q;

endmodule

// File: tb/tb_aes_round_key_gen.sv
// Scoreboard bench for aes_round_key_gen using the FIPS-197 key-expansion vectors.
module tb_aes_round_key_gen;

    logic         clk = 1'b0;
    logic         rst;
    logic         load;
    logic [127:0] key;
    logic         advance;
    logic         rewind;
    logic [127:0] round_ks;
    logic [3:0]   round_idx;
    logic         ks_valid;
    logic         ks_last;

    aes_round_key_gen dut (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .key       (key),
        .advance   (advance),
        .rewind    (rewind),
        .round_ks  (round_ks),
        .round_idx (round_idx),
        .ks_valid  (ks_valid),
        .ks_last   (ks_last)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [127:0] ks;
        logic [3:0]   idx;
        logic         v;
        logic         l;
        string        nm;
    } exp_t;

    exp_t q[$];
    int   n_vec = 0;
    int   n_bad = 0;

    localparam logic [127:0] KEY_A = 128'h2b7e151628aed2a6abf7158809cf4f3c;

    logic [127:0] RK [0:10] = '{
        128'h2b7e151628aed2a6abf7158809cf4f3c,
        128'ha0fafe1788542cb123a339392a6c7605,
        128'hf2c295f27a96b9435935807a7359f67f,
        128'h3d80477d4716fe3e1e237e446d7a883b,
        128'hef44a541a8525b7fb671253bdb0bad00,
        128'hd4d1c6f87c839d87caf2b8bc11f915bc,
        128'h6d88a37a110b3efddbf98641ca0093fd,
        128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
        128'head27321b58dbad2312bf5607f8d292f,
        128'hac7766f319fadc2128d12941575c006e,
        128'hd014f9a8c9ee2589e13f0cc8b6630ca6
    };

    // All-zero key: rounds 0..2 only.
    logic [127:0] ZK [0:2] = '{
        128'h00000000000000000000000000000000,
        128'h62636363626363636263636362636363,
        128'h9b9898c9f9fbfbaa9b9898c9f9fbfbaa
    };

`ifdef KS_REWIND_EN
    localparam bit REW_EN = 1'b1;
`else
    localparam bit REW_EN = 1'b0;
`endif

    int m_sel = 0;
    int m_idx = 0;
    bit m_valid = 1'b0;

    function automatic exp_t model_exp(input string nm);
        exp_t e;
        e.nm  = nm;
        e.v   = m_valid;
        e.idx = 4'(m_idx);
        e.l   = m_valid && (m_idx == 10);
        if (!m_valid)        e.ks = '0;
        else if (m_sel == 0) e.ks = RK[m_idx];
        else                 e.ks = ZK[m_idx];
        return e;
    endfunction

    task automatic chk(input exp_t e);
        n_vec++;
        if (round_ks !== e.ks || round_idx !== e.idx || ks_valid !== e.v || ks_last !== e.l) begin
            n_bad++;
            $display("FAIL %s: got ks=%h idx=%0d v=%b l=%b, want ks=%h idx=%0d v=%b l=%b",
                     e.nm, round_ks, round_idx, ks_valid, ks_last, e.ks, e.idx, e.v, e.l);
        end
    endtask

    // Applies one cycle of stimulus and queues the expected post-edge outputs.
    task automatic cyc(input bit ld, input int sel, input bit adv, input bit rw, input string nm);
        load    = ld;
        key     = ld ? ((sel == 0) ? KEY_A : 128'h0) : 128'h0123456789abcdeffedcba9876543210;
        advance = adv;
        rewind  = rw;
        if (ld) begin
            m_sel   = sel;
            m_idx   = 0;
            m_valid = 1'b1;
        end else if (rw && REW_EN && m_valid) begin
            m_idx = 0;
        end else if (adv && m_valid && m_idx < 10) begin
            m_idx++;
        end
        @(posedge clk);
        #1;
        q.push_back(model_exp(nm));
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) chk(q.pop_front());
    end

    initial begin
        #200us;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t z;
        z.ks = '0; z.idx = '0; z.v = 1'b0; z.l = 1'b0;

        rst = 1'b0; load = 1'b1; key = KEY_A; advance = 1'b1; rewind = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        z.nm = "rst_hold";
        chk(z);
        load = 1'b0; advance = 1'b0; rewind = 1'b0;
        rst = 1'b1;

        cyc(0, 0, 1, 0, "adv_unloaded_a");
        cyc(0, 0, 1, 0, "adv_unloaded_b");
        cyc(0, 0, 0, 1, "rew_unloaded");

        cyc(1, 0, 0, 0, "load_r0");
        cyc(0, 0, 1, 0, "adv_r1");

        cyc(1, 0, 0, 0, "reload_r0");
        for (int i = 1; i <= 10; i++) cyc(0, 0, 1, 0, $sformatf("burst_r%0d", i));
        cyc(0, 0, 1, 0, "adv_past_nr");
        cyc(0, 0, 0, 0, "hold_nr");

        cyc(1, 0, 0, 0, "gap_load");
        for (int i = 1; i <= 10; i++) begin
            cyc(0, 0, 1, 0, $sformatf("gap_r%0d", i));
            for (int g = 0; g < 3; g++) cyc(0, 0, 0, 0, $sformatf("gap_hold_r%0d", i));
        end

        cyc(1, 0, 0, 0, "pri_load");
        for (int i = 1; i <= 4; i++) cyc(0, 0, 1, 0, $sformatf("pri_r%0d", i));
        cyc(1, 1, 1, 0, "load_beats_adv");
        cyc(0, 1, 1, 0, "zk_r1");
        cyc(0, 1, 1, 0, "zk_r2");

        cyc(1, 0, 0, 0, "rst_load");
        for (int i = 1; i <= 6; i++) cyc(0, 0, 1, 0, $sformatf("rst_r%0d", i));
        advance = 1'b0;
        @(negedge clk);
        #2;
        rst = 1'b0;
        m_valid = 1'b0;
        m_idx = 0;
        #1;
        z.nm = "async_clear";
        chk(z);
        @(posedge clk);
        #1;
        z.nm = "async_clear_hold";
        chk(z);
        rst = 1'b1;
        cyc(0, 0, 1, 0, "adv_after_rst");
        cyc(0, 0, 0, 1, "rew_after_rst");

        cyc(1, 0, 0, 0, "rew_load");
        for (int i = 1; i <= 10; i++) cyc(0, 0, 1, 0, $sformatf("rew_r%0d", i));
        cyc(0, 0, 0, 1, "rewind_at_nr");
        cyc(0, 0, 1, 0, "adv_after_rewind");

        repeat (2) @(posedge clk);
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d pending expectations, want 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
